wb_keypad_scan_ctrl: RTL and testbench

//  Wishbone-slave scan controller for a 4x4 matrix keypad. Drives the column strobes and samples
//  the rows, debounces whole frames, and queues press/release events in an event FIFO.

---
 rtl/wb_keypad_scan_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_wb_keypad_scan_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_keypad_scan_ctrl.sv
// rtl/wb_keypad_scan_ctrl.sv - Wishbone 4x4 keypad scanner with frame debounce and event FIFO
// Optional macro KEYPAD_GHOST_REJECT_EN discards frames with more than two keys pressed.
module wb_keypad_scan_ctrl #(
  parameter int CLK_FREQ        = 50000000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int FIFO_AW         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic [3:0]  row,
  output logic [3:0]  column,
  output logic        intr
);

  localparam int TICK_DIV = CLK_FREQ / SCAN_HZ;
  localparam int DIV_W    = $clog2(TICK_DIV);
  localparam int DEPTH    = 1 << FIFO_AW;
  localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, SCAN, DIFF} state_t;
  state_t state, state_nxt;

  logic [1:0]       col_idx;
  logic [DIV_W-1:0] div;
  logic [11:0]      raw;
  logic [15:0]      prev;
  logic [3:0]       stable;
  logic [15:0]      frame;
  logic [3:0]       key_idx;
  logic [15:0]      keymap;
  logic             scan_en, irq_en, ovf, ghost_flag;
  logic [4:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count;

  logic        tick, frame_done, ghost_hit, diff_push;
  logic [15:0] cur_frame;
  logic [3:0]  stable_nxt;
  logic        req, rd_pop, wr_ctrl, empty, full, push_ok;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:3]};

  // Column 3 rows are taken live so the frame compare happens on the last tick.
  assign cur_frame = {~row, raw};
  assign tick      = (div == DIV_W'(TICK_DIV - 1));

`ifdef KEYPAD_GHOST_REJECT_EN
  function automatic logic [4:0] ones16(input logic [15:0] v);
    ones16 = '0;
    for (int i = 0; i < 16; i++) ones16 = ones16 + {4'd0, v[i]};
  endfunction
  assign ghost_hit = (ones16(cur_frame) > 5'd2);
`else
  assign ghost_hit = 1'b0;
`endif

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign req     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign rd_pop  = req & ~wb_we_i & (wb_adr_i[3:2] == 2'd1) & ~empty;
  assign wr_ctrl = req & wb_we_i & (wb_adr_i[3:2] == 2'd2);
  assign column  = (state == SCAN) ? ~(4'b0001 << col_idx) : 4'hF;

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    diff_push  = 1'b0;
    stable_nxt = 4'd1;
    if (cur_frame == prev) stable_nxt = (stable == DEB) ? DEB : 4'(stable + 4'd1);
    case (state)
      IDLE: if (scan_en) state_nxt = SCAN;
      SCAN: begin
        if (!scan_en) state_nxt = IDLE;
        else if (tick && col_idx == 2'd3) begin
          frame_done = 1'b1;
          if (!ghost_hit && stable_nxt == DEB && cur_frame != keymap) state_nxt = DIFF;
        end
      end
      DIFF: begin
        diff_push = (frame[key_idx] != keymap[key_idx]);
        if (key_idx == 4'd15) state_nxt = scan_en ? SCAN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
  assign push_ok = diff_push & (~full | rd_pop);

  always_comb begin
    rd_data = '0;
    case (wb_adr_i[3:2])
      2'd0: begin
        rd_data[0]           = ~empty;
        rd_data[1]           = ovf;
        rd_data[2+FIFO_AW:2] = count;
        rd_data[15]          = ghost_flag;
      end
      2'd1: if (!empty) rd_data = {23'd0, 1'b1, 3'd0, mem[rptr]};
      2'd2: rd_data[1:0] = {irq_en, scan_en};
      default: rd_data[15:0] = keymap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      col_idx    <= '0;
      div        <= '0;
      raw        <= '0;
      prev       <= '0;
      stable     <= '0;
      frame      <= '0;
      key_idx    <= '0;
      keymap     <= '0;
      scan_en    <= 1'b0;
      irq_en     <= 1'b0;
      ovf        <= 1'b0;
      ghost_flag <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      intr       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;

      if (state == SCAN && state_nxt == IDLE) begin
        raw    <= '0;
        prev   <= '0;
        stable <= '0;
      end else if (state == SCAN) begin
        div <= tick ? '0 : DIV_W'(div + 1'b1);
        if (tick) begin
          col_idx <= col_idx + 2'd1;
          case (col_idx)
            2'd0: raw[3:0]  <= ~row;
            2'd1: raw[7:4]  <= ~row;
            2'd2: raw[11:8] <= ~row;
            default: ;
          endcase
        end
        if (frame_done) begin
          if (ghost_hit) begin
            stable     <= '0;
            ghost_flag <= 1'b1;
          end else begin
            stable <= stable_nxt;
            prev   <= cur_frame;
          end
          if (state_nxt == DIFF) begin
            frame   <= cur_frame;
            key_idx <= '0;
          end
        end
      end

      if (state != SCAN && state_nxt == SCAN) begin
        col_idx <= '0;
        div     <= '0;
      end

      if (state == DIFF) begin
        key_idx <= key_idx + 4'd1;
        if (diff_push) keymap[key_idx] <= frame[key_idx];
      end

      if (push_ok) begin
        mem[wptr] <= {frame[key_idx], key_idx};
        wptr      <= wptr + 1'b1;
      end
      if (rd_pop) rptr <= rptr + 1'b1;
      case ({push_ok, rd_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (wr_ctrl) begin
        scan_en <= wb_dat_i[0];
        irq_en  <= wb_dat_i[1];
        if (wb_dat_i[2]) begin
          ovf        <= 1'b0;
          ghost_flag <= 1'b0;
        end
      end
      if (diff_push && !push_ok) ovf <= 1'b1;

      wb_ack_o <= req;
      if (req) wb_dat_o <= wb_we_i ? '0 : rd_data;
      intr <= irq_en & ~empty;
    end
  end

endmodule

// File: tb/tb_wb_keypad_scan_ctrl.sv
// tb/tb_wb_keypad_scan_ctrl.sv - directed register vectors and keypad sequences for wb_keypad_scan_ctrl
module tb_wb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_stb_i, wb_cyc_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;
  logic [3:0]  row, column;
  logic        intr;
  logic [15:0] keys;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rdata;
  logic        intr_ack, intr_after;
  logic [3:0]  col_after;

  always #5 clk = ~clk;

  wb_keypad_scan_ctrl #(
    .CLK_FREQ(400), .SCAN_HZ(100), .DEBOUNCE_FRAMES(2), .FIFO_AW(3)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .row(row), .column(column), .intr(intr)
  );

  // Pressed key pulls its row low while its column is strobed.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!column[c]) row = row & ~keys[4*c +: 4];
  end

  typedef struct {
    logic        we;
    logic [1:0]  adr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [1:0] a, input logic [31:0] d, input string name);
    int cyc;
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
    wb_adr_i = {28'd0, a, 2'b00}; wb_dat_i = d;
    cyc = 0; rdata = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (wb_ack_o) begin
        rdata = wb_dat_o;
        break;
      end
    end
    intr_ack = intr;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
    intr_after = intr;
    col_after  = column;
    check({name, "_ack_latency"}, 32'(cyc), 32'd1);
    check({name, "_ack_width"}, {31'd0, wb_ack_o}, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    xfer(1'b0, a, 32'd0, name);
    check(name, rdata, exp);
  endtask

  task automatic wait_intr(input string name);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (intr) break;
    end
    check(name, {31'd0, intr}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'd2, 32'd0,      32'd0, "rst_ctrl"};
    vecs[1] = '{1'b0, 2'd0, 32'd0,      32'd0, "rst_status"};
    vecs[2] = '{1'b0, 2'd3, 32'd0,      32'd0, "rst_keys"};
    vecs[3] = '{1'b0, 2'd1, 32'd0,      32'd0, "rst_event_empty"};
    vecs[4] = '{1'b1, 2'd3, 32'hFFFF,   32'd0, "wr_keys_ro"};
    vecs[5] = '{1'b0, 2'd3, 32'd0,      32'd0, "keys_after_wr"};
    vecs[6] = '{1'b1, 2'd2, 32'h6,      32'd0, "wr_ctrl_6"};
    vecs[7] = '{1'b0, 2'd2, 32'd0,      32'h2, "ctrl_bit2_reads_0"};
    vecs[8] = '{1'b1, 2'd2, 32'h0,      32'd0, "wr_ctrl_0"};
    vecs[9] = '{1'b0, 2'd0, 32'd0,      32'd0, "status_after_wr"};

    rst = 1'b0; keys = '0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_column", {28'd0, column}, 32'hF);
    check("rst_intr", {31'd0, intr}, 32'd0);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].we, vecs[i].adr, vecs[i].wdata, vecs[i].name);
      if (!vecs[i].we) check(vecs[i].name, rdata, vecs[i].exp);
    end
    check("idle_column", {28'd0, column}, 32'hF);

    // Press key 6 (column 1, row 2).
    xfer(1'b1, 2'd2, 32'h3, "en");
    keys[6] = 1'b1;
    wait_intr("press6_intr");
    repeat (20) @(posedge clk);
    rd(2'd3, 32'h0040, "press6_keys");
    rd(2'd0, 32'h5, "press6_status");
    rd(2'd1, 32'h116, "press6_event");
    check("intr_at_pop_ack", {31'd0, intr_ack}, 32'd1);
    check("intr_after_pop", {31'd0, intr_after}, 32'd0);

    keys[6] = 1'b0;
    wait_intr("release6_intr");
    repeat (20) @(posedge clk);
    rd(2'd1, 32'h106, "release6_event");
    rd(2'd1, 32'h000, "empty_event");
    rd(2'd0, 32'h0, "empty_status");

    // Nine toggles of key 0 with no reads: the ninth event overflows.
    for (int i = 0; i < 9; i++) begin
      keys[0] = ~keys[0];
      repeat (100) @(posedge clk);
    end
    rd(2'd0, 32'h23, "ovf_status");
    xfer(1'b1, 2'd2, 32'h7, "clr_ovf");
    rd(2'd0, 32'h21, "ovf_cleared_status");
    rd(2'd2, 32'h3, "ctrl_after_clr");
    rd(2'd1, 32'h110, "oldest_event");
    for (int i = 0; i < 7; i++)
      rd(2'd1, (i % 2 == 0) ? 32'h100 : 32'h110, "drain_event");
    rd(2'd0, 32'h0, "drained_status");
    rd(2'd3, 32'h0001, "keys_key0");

    // Disable mid-frame, then re-enable with an unchanged keypad.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (column == 4'b1101) break;
    end
    check("midframe_col1", {28'd0, column}, 32'hD);
    xfer(1'b1, 2'd2, 32'h2, "disable");
    check("disable_column", {28'd0, col_after}, 32'hF);
    repeat (40) @(posedge clk);
    #1;
    check("idle_hold_column", {28'd0, column}, 32'hF);
    xfer(1'b1, 2'd2, 32'h3, "reenable");
    repeat (100) @(posedge clk);
    rd(2'd0, 32'h0, "reenable_no_event");
    rd(2'd3, 32'h0001, "reenable_keys");

    keys = '0;
    repeat (100) @(posedge clk);
    rd(2'd1, 32'h100, "release0_event");

    keys = 16'h0421;
    repeat (100) @(posedge clk);
`ifdef KEYPAD_GHOST_REJECT_EN
    rd(2'd0, 32'h8000, "ghost_status");
    rd(2'd3, 32'h0000, "ghost_keys");
    xfer(1'b1, 2'd2, 32'h4, "ghost_clr");
    rd(2'd0, 32'h0, "ghost_cleared_status");
`else
    rd(2'd0, 32'hD, "three_key_status");
    rd(2'd3, 32'h0421, "three_key_keys");
    rd(2'd1, 32'h110, "three_key_ev0");
    rd(2'd1, 32'h115, "three_key_ev5");
    rd(2'd1, 32'h11A, "three_key_ev10");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
